// File: rtl/cp_period_meter.sv
// Period meter for the slow CP tick: synchronises CP, times rising edges in Clk cycles,
// and reports period, tolerance lock and stall. Optional glitch filter: CPMETER_DEBOUNCE_EN.
module cp_period_meter #(
    parameter int          CNT_W   = 27,
    parameter int unsigned NOMINAL = 100_000_000,
    parameter int unsigned TOL     = 1000,
    parameter int unsigned TIMEOUT = 120_000_000
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             CP,
    output logic [CNT_W-1:0] Period,
    output logic             Valid,
    output logic             Locked,
    output logic             Timeout
);

`ifdef CPMETER_DEBOUNCE_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   NOM_X     = (CNT_W+1)'(NOMINAL);
    localparam logic [CNT_W:0]   TOL_X     = (CNT_W+1)'(TOL);

    typedef enum logic [1:0] {WAIT_FIRST, MEASURE, STALLED} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   cnt_wide;
    logic             in_tol;

    logic             sync1_reg;
    logic             sync2_reg;
    logic [DEPTH-1:0] hist_reg;
    logic [DEPTH-1:0] hist_next;
    logic             edge_next;
    logic             edge_reg;

    // History of the synchronised level; hist_reg[0] is the previous-value register.
    assign hist_next[0] = sync2_reg;
    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_hist
            assign hist_next[gi] = hist_reg[gi-1];
        end
    endgenerate

`ifdef CPMETER_DEBOUNCE_EN
    // Accept only after four consecutive high samples that follow a low one.
    assign edge_next = sync2_reg & (&hist_reg[2:0]) & ~hist_reg[3];
`else
    assign edge_next = sync2_reg & ~hist_reg[0];
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            hist_reg  <= '0;
            edge_reg  <= 1'b0;
        end else begin
            sync1_reg <= CP;
            sync2_reg <= sync1_reg;
            hist_reg  <= hist_next;
            edge_reg  <= edge_next;
        end
    end

    assign cnt_inc  = cnt_reg + CNT_W'(1);
    assign cnt_wide = {1'b0, cnt_inc};
    // Lower bound checked as period + TOL >= NOMINAL so a TOL above NOMINAL cannot underflow.
    assign in_tol   = ((cnt_wide + TOL_X) >= NOM_X) && (cnt_wide <= (NOM_X + TOL_X));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= WAIT_FIRST;
            cnt_reg   <= '0;
            Period    <= '0;
            Valid     <= 1'b0;
            Locked    <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            Valid <= 1'b0;
            case (state_reg)
                WAIT_FIRST: begin
                    cnt_reg <= '0;
                    if (edge_reg) begin
                        state_reg <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_reg) begin
                        Period  <= cnt_inc;
                        Valid   <= 1'b1;
                        Locked  <= in_tol;
                        cnt_reg <= '0;
                    end else if (cnt_inc == TIMEOUT_C) begin
                        // Counter freezes here; Period keeps the last good measurement.
                        state_reg <= STALLED;
                        Timeout   <= 1'b1;
                        Locked    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                STALLED: begin
                    if (edge_reg) begin
                        state_reg <= MEASURE;
                        cnt_reg   <= '0;
                        Timeout   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= WAIT_FIRST;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp_period_meter.sv
// Directed, table-driven bench for cp_period_meter with small parameters (period 10, timeout 32).
module tb_cp_period_meter;

    localparam int CNT_W = 8;
`ifdef CPMETER_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cp;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             locked;
    logic             timeout;

    always #5 clk = ~clk;

    cp_period_meter #(
        .CNT_W  (CNT_W),
        .NOMINAL(10),
        .TOL    (1),
        .TIMEOUT(32)
    ) dut (
        .Clk    (clk),
        .Rst    (rst),
        .CP     (cp),
        .Period (period),
        .Valid  (valid),
        .Locked (locked),
        .Timeout(timeout)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // One row = one stretch of CP stimulus; bit j of pat is CP during step j of the row.
    typedef struct {
        string       name;
        int          len;
        logic [31:0] pat;
        int          rst_at;
        int          exp_nval;
        int          exp_pos;
        int          exp_period;
        int          exp_locked;
        int          exp_tout;
    } vec_t;

    function automatic vec_t mk(input string name, input int len, input logic [31:0] pat,
                                input int rst_at, input int exp_nval, input int exp_pos,
                                input int exp_period, input int exp_locked, input int exp_tout);
        vec_t v;
        v.name = name; v.len = len; v.pat = pat; v.rst_at = rst_at;
        v.exp_nval = exp_nval; v.exp_pos = exp_pos; v.exp_period = exp_period;
        v.exp_locked = exp_locked; v.exp_tout = exp_tout;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled on the falling edge.
    task automatic apply(input vec_t v);
        int nval = 0;
        int first_pos = -1;
        int last_period = -1;
        int last_locked = -1;
        for (int j = 0; j < v.len; j++) begin
            cp  = v.pat[j];
            rst = (j == v.rst_at);
            @(negedge clk);
            if (j == v.rst_at) begin
                chk({v.name, "_rst_period"}, int'(period), 0);
                chk({v.name, "_rst_valid"}, int'(valid), 0);
                chk({v.name, "_rst_locked"}, int'(locked), 0);
                chk({v.name, "_rst_timeout"}, int'(timeout), 0);
            end
            if (valid) begin
                nval++;
                if (first_pos < 0) first_pos = j;
                last_period = int'(period);
                last_locked = int'(locked);
            end
        end
        rst = 1'b0;
        $display("row %s: valids=%0d first_at=%0d period=%0d locked=%0d timeout=%0d",
                 v.name, nval, first_pos, last_period, last_locked, timeout);
        chk({v.name, "_nvalid"}, nval, v.exp_nval);
        if (v.exp_nval > 0) begin
            chk({v.name, "_valid_pos"}, first_pos, v.exp_pos);
            chk({v.name, "_period"}, last_period, v.exp_period);
            chk({v.name, "_locked"}, last_locked, v.exp_locked);
        end
        chk({v.name, "_timeout"}, int'(timeout), v.exp_tout);
    endtask

    vec_t vecs[7];

    initial begin
        int t_idx;
        int pre_locked;
        int hold_nval;

        vecs[0] = mk("first_edge", 10, 32'h1F, -1, 0, 0, 0, 0, 0);
        vecs[1] = mk("sq10_a",     10, 32'h1F, -1, 1, LAT, 10, 1, 0);
        vecs[2] = mk("sq10_b",     10, 32'h1F, -1, 1, LAT, 10, 1, 0);
        vecs[3] = mk("to_13",      13, 32'h7F, -1, 1, LAT, 10, 1, 0);
        vecs[4] = mk("meas_13",    10, 32'h1F, -1, 1, LAT, 13, 0, 0);
        vecs[5] = mk("to_11",      11, 32'h3F, -1, 1, LAT, 10, 1, 0);
        vecs[6] = mk("meas_11",    10, 32'h1F, -1, 1, LAT, 11, 1, 0);

        rst = 1'b1;
        cp  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_period", int'(period), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_timeout", int'(timeout), 0);

        for (int i = 0; i < 7; i++) apply(vecs[i]);

        // Hold CP low after the last edge until the stall is flagged.
        t_idx = -1;
        pre_locked = -1;
        hold_nval = 0;
        for (int j = 10; j < 80 && t_idx < 0; j++) begin
            cp = 1'b0;
            @(negedge clk);
            if (valid) hold_nval++;
            if (timeout) begin
                t_idx = j;
                chk("timeout_locked", int'(locked), 0);
                chk("timeout_period_kept", int'(period), 11);
            end else begin
                pre_locked = int'(locked);
            end
        end
        $display("stall: timeout_at=%0d locked_before=%0d valids=%0d", t_idx, pre_locked, hold_nval);
        chk("timeout_cycle", t_idx, LAT + 32);
        chk("locked_before_timeout", pre_locked, 1);
        chk("hold_nvalid", hold_nval, 0);

        apply(mk("stall_exit",  10, 32'h1F, -1, 0, 0, 0, 0, 0));
        apply(mk("after_stall", 10, 32'h1F, -1, 1, LAT, 10, 1, 0));

        apply(mk("rst_mid",  14, 32'h1F, LAT + 5, 1, LAT, 10, 1, 0));
        apply(mk("rst_next", 10, 32'h1F, -1, 0, 0, 0, 0, 0));
        apply(mk("rst_meas", 10, 32'h1F, -1, 1, LAT, 10, 1, 0));

        // Two-cycle glitch in the low phase (bits 6..7).
`ifdef CPMETER_DEBOUNCE_EN
        apply(mk("glitch",      10, 32'hDF, -1, 1, LAT, 10, 1, 0));
        apply(mk("post_glitch", 10, 32'h1F, -1, 1, LAT, 10, 1, 0));
`else
        apply(mk("glitch",      10, 32'hDF, -1, 2, LAT, 6, 0, 0));
        apply(mk("post_glitch", 10, 32'h1F, -1, 1, LAT, 4, 0, 0));
`endif
        apply(mk("recovered", 10, 32'h1F, -1, 1, LAT, 10, 1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cp_period_meter.md
# cp_period_meter

Measures the period of the slow `CP` tick in `Clk` cycles; this is the receiving end of the tick produced by the clock divider. It synchronises `CP` into the `Clk` domain and counts `Clk` cycles between successive rising edges. It reports each measured period, flags whether the period is within tolerance of nominal, and flags a stalled tick. It sits beside the divider as a self-check for board bring-up and for the verification bench.

## Interface
Parameters:
- `CNT_W`, 27: width of the period counter and of `Period`.
- `NOMINAL`, 100_000_000: expected period in `Clk` cycles (1 s at 100 MHz).
- `TOL`, 1000: allowed absolute deviation from `NOMINAL` for `Locked`.
- `TIMEOUT`, 120_000_000: cycles without a rising edge before the tick is declared stalled; must be greater than `NOMINAL + TOL` and less than 2^`CNT_W`.

Ports:
- `Clk`, input, 1: system clock, 100 MHz.
- `Rst`, input, 1: synchronous, active-high reset.
- `CP`, input, 1: tick under measurement; asynchronous to `Clk`.
- `Period`, output, `CNT_W`: last measured period in `Clk` cycles.
- `Valid`, output, 1: one-cycle pulse when `Period` has just been updated.
- `Locked`, output, 1: last measured period is within `NOMINAL ± TOL`.
- `Timeout`, output, 1: level; the tick is stalled.

## Operation
- Input conditioning:
  - `CP` passes through a 2-flop synchroniser, then a previous-value register.
  - `edge` = synced & ~prev.
  - All three flops reset to 0. A `CP` that is high at reset release therefore yields one `edge`.
- The FSM has three states: `WAIT_FIRST`, `MEASURE`, `STALLED`.
- `WAIT_FIRST` (reset state):
  - The counter is held at 0.
  - On `edge`: go to `MEASURE` and clear the counter to 0. No `Valid`.
- `MEASURE`:
  - The counter increments by 1 each cycle.
  - On `edge`: `Period` <= counter + 1, `Valid` = 1 for one cycle, counter <= 0, stay in `MEASURE`.
  - Consequence: edges detected at cycles t and t+N give `Period` = N.
  - If counter + 1 == `TIMEOUT` without an edge: go to `STALLED`. On that cycle `Timeout` <= 1 and `Locked` <= 0. The counter freezes. `Period` keeps its old value.
  - `edge` on the same cycle as the timeout threshold: the edge wins and is handled as a normal measurement. No timeout.
- `STALLED`:
  - `Timeout` stays 1.
  - On `edge`: go to `MEASURE`, clear the counter, set `Timeout` <= 0. No `Valid`, because the stalled interval is not a valid period.
- `Locked`:
  - Updated only when `Valid` fires.
  - Set to 1 when `NOMINAL - TOL` <= new `Period` <= `NOMINAL + TOL`, otherwise 0.
  - Comparison is unsigned, `CNT_W`+1 bits wide, so no underflow occurs when `TOL` > `NOMINAL`.
- The counter never wraps, because `TIMEOUT` bounds it.

## Timing
- Reset values: `Period` = 0, `Valid` = 0, `Locked` = 0, `Timeout` = 0, state `WAIT_FIRST`.
- Reset dominates all other events. Reset mid-measurement discards the partial count and produces no `Valid`.
- Latency: let k be the `Clk` edge at which the first synchroniser flop captures `CP`=1.
  - `edge` is high in the cycle after edge k+2.
  - `Period`/`Valid` update at edge k+3.
- `Valid` is never asserted on two consecutive cycles. The minimum measurable period is 2 cycles.
- `CP` high time must be at least 2 `Clk` cycles for reliable detection.

## Configuration
- `CPMETER_DEBOUNCE_EN`:
  - Defined: an edge is accepted only after the synchronised `CP` has been 1 for 4 consecutive cycles following a 0. Shorter high pulses are ignored. Latency grows by 3 cycles. Measured `Period` for a clean input is unchanged.
  - Undefined: raw synchronised edge detection as described above.

## Test plan
All scenarios use `CNT_W`=8, `NOMINAL`=10, `TOL`=1, `TIMEOUT`=32.
- Reset, then a `CP` square wave with period 10 `Clk` cycles:
  - No `Valid` after the first edge.
  - A `Valid` pulse every 10 cycles with `Period`=10 and `Locked`=1.
  - The first `Valid` arrives 3 cycles after synchroniser capture of the second edge.
- `CP` period switched to 13 cycles → next `Valid` gives `Period`=13, `Locked`=0. Back to 11 → `Period`=11, `Locked`=1.
- `CP` held low after lock → at 32 cycles after the last edge, `Timeout`=1 and `Locked`=0. Next edge → `Timeout`=0, no `Valid`. Following edge 10 cycles later → `Period`=10, `Valid`.
- `Rst` pulsed at cycle 5 of a 10-cycle measurement → all outputs 0. The next edge produces no `Valid`. The edge after it gives `Period`=10.
- With `CPMETER_DEBOUNCE_EN`, a 2-cycle glitch inserted mid-period → ignored, `Period` stays 10. Without the macro → two short periods reported (`Valid` twice, `Locked`=0).
